// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with grant hold and burst limit.
// One requester owns the resource while it keeps its request asserted, for
// at most MAX_HOLD consecutive cycles. After that, or as soon as it drops its
// request, ownership moves to the next requester in round-robin order.
// All outputs are registered.
module rr_grant_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4,
  parameter int ID_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q;
  logic [ID_W-1:0]   ptr_q;
  logic [CNT_W-1:0]  hold_cnt_q;
  logic [N-1:0]      grant_q;
  logic              grant_valid_q;
  logic [ID_W-1:0]   grant_id_q;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [N-1:0]      win_onehot;
  logic [ID_W-1:0]   ptr_d;
  logic [ID_W-1:0]   cand;
  logic              hold_keep;

  // Round-robin search: first requester at or after ptr, wrapping modulo N.
  // On a timeout the owner sits at ptr-1, so it is naturally reached last.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    ptr_d      = ptr_q;
    cand       = '0;
    for (int off = 0; off < N; off++) begin
      cand = ID_W'((int'(ptr_q) + off) % N);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    if (win_found) begin
      win_onehot[win_idx] = 1'b1;
      ptr_d = (int'(win_idx) == N - 1) ? '0 : win_idx + ID_W'(1);
    end
  end

  // Owner keeps the grant while requesting and below its burst limit.
  always_comb begin
    hold_keep = (state_q == BUSY) && req[grant_id_q] && (hold_cnt_q < HOLD_LAST);
  end

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
    end else begin
      if (hold_keep) begin
        hold_cnt_q <= hold_cnt_q + CNT_W'(1);
      end else if (win_found) begin
        // New owner (or the same owner re-granted) with no idle bubble.
        state_q       <= BUSY;
        grant_q       <= win_onehot;
        grant_valid_q <= 1'b1;
        grant_id_q    <= win_idx;
        hold_cnt_q    <= '0;
        ptr_q         <= ptr_d;
      end else begin
        // Nobody requesting: go idle, keep ptr and last grant_id.
        state_q       <= IDLE;
        grant_q       <= '0;
        grant_valid_q <= 1'b0;
        hold_cnt_q    <= '0;
      end
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule
